// File: rtl/cfu_cmd_master_if.sv
// ---------------------------------------------------------------------------
// cfu_cmd_master_if
//
// Bundles the CFU command/response channel between an initiator and the
// accelerator's cmd/rsp port.
//
//   cmd_valid                 initiator -> responder  command valid
//   cmd_ready                 responder -> initiator  command accepted
//   cmd_payload_function_id   initiator -> responder  {op[6:0], 3'b000}
//   cmd_payload_inputs_0      initiator -> responder  operand 0
//   cmd_payload_inputs_1      initiator -> responder  operand 1
//   rsp_valid                 responder -> initiator  response valid
//   rsp_ready                 initiator -> responder  response accepted
//   rsp_payload_outputs_0     responder -> initiator  response data
//
// Modports: master (the command initiator), slave (the accelerator side).
// ---------------------------------------------------------------------------
interface cfu_cmd_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;

   modport master (
      output cmd_valid,
      output cmd_payload_function_id,
      output cmd_payload_inputs_0,
      output cmd_payload_inputs_1,
      output rsp_ready,
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_payload_outputs_0
   );

   modport slave (
      input  cmd_valid,
      input  cmd_payload_function_id,
      input  cmd_payload_inputs_0,
      input  cmd_payload_inputs_1,
      input  rsp_ready,
      output cmd_ready,
      output rsp_valid,
      output rsp_payload_outputs_0
   );
endinterface

// File: rtl/cfu_cmd_master.sv
// ---------------------------------------------------------------------------
// cfu_cmd_master
//
// Hardware initiator for the CFU cmd/rsp custom-instruction port. It runs
// bulk tile transfers so the CPU does not have to issue them one by one.
//   Load job     : one func-0 write per byte taken from the s_* stream.
//   Readback job : one func-4 read per element, results streamed on m_*.
// Only one command is ever outstanding on the cmd/rsp channel.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   job_valid/job_ready      job request handshake (ready only when idle)
//   job_op                   0 = load, 1 = readback
//   job_base, job_count      starting row index, number of elements
//   busy, done               activity flag, one-cycle completion pulse
//   s_valid/s_ready/s_data   load byte stream
//   m_valid/m_ready/m_data   readback result stream
//   bus                      cmd/rsp channel (cfu_cmd_master_if.master)
// ---------------------------------------------------------------------------
module cfu_cmd_master #(
   parameter int TILE_SIZE  = 32,
   parameter int COUNT_BITS = 16,
   parameter int INDEX_BITS = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic                  job_op,
   input  logic [INDEX_BITS-1:0] job_base,
   input  logic [COUNT_BITS-1:0] job_count,
   output logic                  busy,
   output logic                  done,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [7:0]            s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [31:0]           m_data,
   cfu_cmd_master_if.master      bus
);

   localparam int BANK_BITS = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
   localparam logic [9:0] FUNC_WRITE = {7'd0, 3'b000};
   localparam logic [9:0] FUNC_READ  = {7'd4, 3'b000};

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_RSP, DRAIN, DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic                  op;
   logic [COUNT_BITS-1:0] count;
   logic [COUNT_BITS-1:0] elem;
   logic [COUNT_BITS-1:0] elem_inc;
   logic                  last;
   logic [BANK_BITS-1:0]  bank;
   logic [BANK_BITS-1:0]  bank_adv;
   logic [INDEX_BITS-1:0] row;
   logic [INDEX_BITS-1:0] row_adv;
   logic [9:0]            func_id;
   logic [31:0]           in0;
   logic [31:0]           in1;

   function automatic logic [31:0] row_word(input logic [INDEX_BITS-1:0] r);
      return {16'b0, 16'(r)};
   endfunction

   function automatic logic [31:0] bank_word(input logic [BANK_BITS-1:0] b);
      return {16'b0, 16'(b)};
   endfunction

   // Element bookkeeping: bank/row walk in step with the element counter,
   // so no divider is needed. Row wraps naturally at 2^INDEX_BITS.
   always_comb begin
      elem_inc = elem + COUNT_BITS'(1);
      last     = (elem_inc == count);
      bank_adv = bank + BANK_BITS'(1);
      row_adv  = row;
      if (bank == BANK_BITS'(TILE_SIZE - 1)) begin
         bank_adv = '0;
         row_adv  = row + INDEX_BITS'(1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. All strobes are decoded from the
   // state so that a reset immediately silences cmd_valid and done.
   always_comb begin
      state_next    = state;
      job_ready     = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      s_ready       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      case (state)
         IDLE: begin
            job_ready = 1'b1;
            busy      = 1'b0;
            if (job_valid) begin
               if (job_count == '0) begin
                  state_next = DONE;
               end else if (job_op) begin
                  state_next = ISSUE;
               end else begin
                  state_next = FETCH;
               end
            end
         end
         FETCH: begin
            s_ready = 1'b1;
            if (s_valid) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            bus.cmd_valid = 1'b1;
            if (bus.cmd_ready) begin
               state_next = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            // Kept high for the whole state: the response may be a single pulse.
            bus.rsp_ready = 1'b1;
            if (bus.rsp_valid) begin
               if (op) begin
                  state_next = DRAIN;
               end else if (last) begin
                  state_next = DONE;
               end else begin
                  state_next = FETCH;
               end
            end
         end
         DRAIN: begin
            if (m_ready) begin
               state_next = last ? DONE : ISSUE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Job context, counters and the registered command payload. The payload
   // is loaded on the transition into ISSUE so it stays frozen while the
   // responder holds off cmd_ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         op      <= 1'b0;
         count   <= '0;
         elem    <= '0;
         bank    <= '0;
         row     <= '0;
         func_id <= '0;
         in0     <= '0;
         in1     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (job_valid) begin
                  op    <= job_op;
                  count <= job_count;
                  elem  <= '0;
                  bank  <= '0;
                  row   <= job_base;
                  if (job_op) begin
                     func_id <= FUNC_READ;
                     in0     <= row_word(job_base);
                     in1     <= bank_word('0);
                  end
               end
            end
            FETCH: begin
               if (s_valid) begin
                  func_id <= FUNC_WRITE;
                  in0     <= {24'b0, s_data};
                  in1     <= {16'(bank), 16'(row)};
               end
            end
            WAIT_RSP: begin
               if (bus.rsp_valid) begin
                  if (op) begin
                     m_data  <= bus.rsp_payload_outputs_0;
                     m_valid <= 1'b1;
                  end else begin
                     elem <= elem_inc;
                     bank <= bank_adv;
                     row  <= row_adv;
                  end
               end
            end
            DRAIN: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  elem    <= elem_inc;
                  bank    <= bank_adv;
                  row     <= row_adv;
                  in0     <= row_word(row_adv);
                  in1     <= bank_word(bank_adv);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.cmd_payload_function_id = func_id;
   assign bus.cmd_payload_inputs_0    = in0;
   assign bus.cmd_payload_inputs_1    = in1;

endmodule
